// File: rtl/decim3_avg_pkg.sv
// -----------------------------------------------------------------------------
// decim3_avg_pkg
// Shared constants for the divide-by-3 boxcar decimator.
//   DECIM_FACTOR : samples per output frame
//   RECIP_COEF   : fixed-point reciprocal of 3 (2^16 / 3, rounded up)
//   ROUND_CONST  : half an LSB at the 2^16 scale, for round-to-nearest
//   SCALE_SHIFT  : right shift that removes the 2^16 scale
// -----------------------------------------------------------------------------
package decim3_avg_pkg;

  localparam int DECIM_FACTOR = 3;
  localparam int RECIP_COEF   = 21846;
  localparam int ROUND_CONST  = 32768;
  localparam int SCALE_SHIFT  = 16;

  // Phase counter type: holds 0..DECIM_FACTOR-1.
  typedef logic [1:0] phase_t;

  localparam phase_t PHASE_FIRST = 2'd0;
  localparam phase_t PHASE_LAST  = phase_t'(DECIM_FACTOR - 1);

endpackage

// File: rtl/decim3_avg_sat_round.sv
// -----------------------------------------------------------------------------
// sat_round
// Combinational scaling stage: out = sat((sum * RECIP_COEF + ROUND_CONST) >>> SCALE_SHIFT)
// Ports:
//   sum_in  : signed frame sum, DATA_W+2 bits
//   out_val : signed result saturated to the DATA_W range
// -----------------------------------------------------------------------------
module sat_round
  import decim3_avg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W+1:0] sum_in,
  output logic signed [DATA_W-1:0] out_val
);

  // Sum width plus coefficient scale; the coefficient is below 2^15 so the
  // product always fits with a sign bit to spare.
  localparam int PROD_W = DATA_W + 2 + SCALE_SHIFT;

  localparam logic signed [PROD_W-1:0] COEF_EXT  = PROD_W'(RECIP_COEF);
  localparam logic signed [PROD_W-1:0] ROUND_EXT = PROD_W'(ROUND_CONST);
  localparam logic signed [PROD_W-1:0] SAT_MAX   =
    {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN   =
    {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] sum_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;

  always_comb begin
    sum_ext = PROD_W'(sum_in);
    product = sum_ext * COEF_EXT;
    rounded = product + ROUND_EXT;
    shifted = rounded >>> SCALE_SHIFT;
    // The coefficient is slightly above 1/3, so full-scale frames can land
    // one LSB past the output range; clamp instead of wrapping.
    if (shifted > SAT_MAX) begin
      out_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      out_val = SAT_MIN[DATA_W-1:0];
    end else begin
      out_val = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/decim3_avg.sv
// -----------------------------------------------------------------------------
// decim3_avg
// Decimate-by-3 boxcar averager with a 2-stage output pipeline.
// Ports:
//   clk_in    : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   sync      : discard the partial frame and restart at phase 0
//   in_valid  : in_data carries a sample this cycle
//   in_data   : signed input sample (DATA_W)
//   out_valid : one-cycle strobe per completed frame
//   out_data  : signed averaged sample, held between strobes
//   phase     : samples accepted so far in the current frame (0..2)
// -----------------------------------------------------------------------------
module decim3_avg
  import decim3_avg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     sync,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [1:0]               phase
);

  // Three DATA_W samples sum to at most 1.5 * 2^DATA_W in magnitude.
  localparam int ACC_W = DATA_W + 2;

  phase_t                    phase_q, phase_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d;
  logic                      pipe_valid_q, pipe_valid_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;

  logic signed [ACC_W-1:0]   in_ext;
  logic signed [DATA_W-1:0]  scaled;

  sat_round #(
    .DATA_W (DATA_W)
  ) u_sat_round (
    .sum_in  (sum_q),
    .out_val (scaled)
  );

  always_comb begin
    in_ext       = ACC_W'(in_data);
    phase_d      = phase_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    pipe_valid_d = 1'b0;
    // Stage 2: a sum registered last cycle becomes the output now.
    out_valid_d  = pipe_valid_q;
    out_data_d   = pipe_valid_q ? scaled : out_data_q;

    if (sync) begin
      // Restart the frame; a sample arriving with sync is its first sample.
      // The pipeline stage above is untouched, so a finished frame still emits.
      if (in_valid) begin
        acc_d   = in_ext;
        phase_d = PHASE_FIRST + phase_t'(1);
      end else begin
        acc_d   = '0;
        phase_d = PHASE_FIRST;
      end
    end else if (in_valid) begin
      if (phase_q == PHASE_FIRST) begin
        acc_d   = in_ext;
        phase_d = phase_q + phase_t'(1);
      end else if (phase_q == PHASE_LAST) begin
        // Stage 1: frame complete, register the full sum.
        sum_d        = acc_q + in_ext;
        pipe_valid_d = 1'b1;
        phase_d      = PHASE_FIRST;
      end else begin
        acc_d   = acc_q + in_ext;
        phase_d = phase_q + phase_t'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PHASE_FIRST;
      acc_q        <= '0;
      sum_q        <= '0;
      pipe_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      pipe_valid_q <= pipe_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign phase     = phase_q;

endmodule
